// File: rtl/ksz_bus_engine.sv
// Host-side bus master for a KSZ-style Ethernet controller: sequences the chip reset,
// then runs register and DMA transfers as address/data phases with programmable strobe timing.
module ksz_bus_engine #(
  parameter int DW             = 16,
  parameter int SETUP_CYC      = 1,
  parameter int STROBE_CYC     = 2,
  parameter int HOLD_CYC       = 1,
  parameter int RST_ASSERT_CYC = 491520,
  parameter int RST_WAIT_CYC   = 2097151
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          soft_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_dma,
  input  logic          cmd_write,
  input  logic          cmd_word,
  input  logic [7:0]    cmd_addr,
  input  logic [7:0]    cmd_len,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          init_req,
  input  logic          init_ack,
  output logic          busy,
  output logic          eth_rstn,
  output logic          eth_cmd,
  output logic          eth_rdn,
  output logic          eth_wrn,
  output logic [DW-1:0] sd_out,
  output logic          sd_oe,
  input  logic [DW-1:0] sd_in
);

  typedef enum logic [3:0] {
    RST_ASSERT, RST_WAIT, IDLE,
    ADDR_SETUP, ADDR_STROBE, ADDR_HOLD,
    DATA_SETUP, DATA_STROBE, DATA_HOLD
  } state_t;

  localparam int MAX_RST = (RST_ASSERT_CYC > RST_WAIT_CYC) ? RST_ASSERT_CYC : RST_WAIT_CYC;
  localparam int MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_BUS = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
  localparam int CNT_MAX = (MAX_RST > MAX_BUS) ? MAX_RST : MAX_BUS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RA_LAST     = CW'(RST_ASSERT_CYC - 1);
  localparam logic [CW-1:0] RW_LAST     = CW'(RST_WAIT_CYC - 1);
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    rem_q, rem_d;
  logic          write_q, write_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          wr_ready_q, wr_ready_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          init_req_q, init_req_d;
  logic          busy_q, busy_d;
  logic          eth_rstn_q, eth_rstn_d;
  logic          eth_cmd_q, eth_cmd_d;
  logic          eth_rdn_q, eth_rdn_d;
  logic          eth_wrn_q, eth_wrn_d;
  logic [DW-1:0] sd_out_q, sd_out_d;
  logic          sd_oe_q, sd_oe_d;

  logic [3:0]    be;
  logic [15:0]   addr_word;
  logic          in_addr, in_data;

  always_comb begin
    be[0] = (cmd_addr[1:0] == 2'd0);
    be[1] = (cmd_word && cmd_addr[1:0] == 2'd0) || (!cmd_word && cmd_addr[1:0] == 2'd1);
    be[2] = (cmd_addr[1:0] == 2'd2);
    be[3] = (cmd_word && cmd_addr[1:0] == 2'd2) || (!cmd_word && cmd_addr[1:0] == 2'd3);
    addr_word = {be, 4'b0000, cmd_addr};
  end

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    write_d     = write_q;
    rd_data_d   = rd_data_q;
    sd_out_d    = sd_out_q;
    init_req_d  = init_ack ? 1'b0 : init_req_q;
    cmd_ready_d = 1'b0;
    wr_ready_d  = 1'b0;
    rd_valid_d  = 1'b0;

    if (soft_rst) begin
      state_d    = RST_ASSERT;
      cnt_d      = '0;
      init_req_d = 1'b0;
    end else begin
      unique case (state_q)
        RST_ASSERT: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == RA_LAST) begin
            state_d = RST_WAIT;
            cnt_d   = '0;
          end
        end
        RST_WAIT: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == RW_LAST) begin
            state_d    = IDLE;
            cnt_d      = '0;
            init_req_d = 1'b1;
          end
        end
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready_d = 1'b1;
            write_d     = cmd_write;
            rem_d       = (cmd_dma && cmd_len != 8'd0) ? cmd_len : 8'd1;
            sd_out_d    = DW'(addr_word);
            state_d     = cmd_dma ? DATA_SETUP : ADDR_SETUP;
            cnt_d       = '0;
          end
        end
        ADDR_SETUP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SETUP_LAST) begin
            state_d = ADDR_STROBE;
            cnt_d   = '0;
          end
        end
        ADDR_STROBE: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == STROBE_LAST) begin
            state_d = ADDR_HOLD;
            cnt_d   = '0;
          end
        end
        ADDR_HOLD: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == HOLD_LAST) begin
            state_d = DATA_SETUP;
            cnt_d   = '0;
          end
        end
        DATA_SETUP: begin
          // A write waits here, counter frozen, until the next word is offered.
          if (!write_q || wr_valid) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SETUP_LAST) begin
              state_d    = DATA_STROBE;
              cnt_d      = '0;
              wr_ready_d = write_q;
            end
          end
        end
        DATA_STROBE: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == STROBE_LAST) begin
            state_d = DATA_HOLD;
            cnt_d   = '0;
            if (!write_q) begin
              rd_data_d  = sd_in;
              rd_valid_d = 1'b1;
            end
          end
        end
        DATA_HOLD: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            rem_d   = rem_q - 8'd1;
            state_d = (rem_q == 8'd1) ? IDLE : DATA_SETUP;
          end
        end
        default: begin
          state_d = RST_ASSERT;
          cnt_d   = '0;
        end
      endcase
    end

    in_addr = (state_d == ADDR_SETUP) || (state_d == ADDR_STROBE) || (state_d == ADDR_HOLD);
    in_data = (state_d == DATA_SETUP) || (state_d == DATA_STROBE) || (state_d == DATA_HOLD);

    // Write data tracks wr_data during setup and freezes once the strobe starts.
    if (write_d && (state_d == DATA_SETUP || (state_q == DATA_SETUP && state_d == DATA_STROBE)))
      sd_out_d = wr_data;

    eth_rstn_d = (state_d != RST_ASSERT);
    eth_cmd_d  = in_addr;
    sd_oe_d    = in_addr || (in_data && write_d);
    eth_wrn_d  = !((state_d == ADDR_STROBE) || (state_d == DATA_STROBE && write_d));
    eth_rdn_d  = !(state_d == DATA_STROBE && !write_d);
    busy_d     = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= RST_ASSERT;
      cnt_q       <= '0;
      rem_q       <= '0;
      write_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      init_req_q  <= 1'b0;
      busy_q      <= 1'b1;
      eth_rstn_q  <= 1'b0;
      eth_cmd_q   <= 1'b0;
      eth_rdn_q   <= 1'b1;
      eth_wrn_q   <= 1'b1;
      sd_out_q    <= '0;
      sd_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      write_q     <= write_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      init_req_q  <= init_req_d;
      busy_q      <= busy_d;
      eth_rstn_q  <= eth_rstn_d;
      eth_cmd_q   <= eth_cmd_d;
      eth_rdn_q   <= eth_rdn_d;
      eth_wrn_q   <= eth_wrn_d;
      sd_out_q    <= sd_out_d;
      sd_oe_q     <= sd_oe_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign init_req  = init_req_q;
  assign busy      = busy_q;
  assign eth_rstn  = eth_rstn_q;
  assign eth_cmd   = eth_cmd_q;
  assign eth_rdn   = eth_rdn_q;
  assign eth_wrn   = eth_wrn_q;
  assign sd_out    = sd_out_q;
  assign sd_oe     = sd_oe_q;

endmodule
